// File: rtl/fp_alu_scheduler.sv
// fp_alu_scheduler_fifo: small circular result buffer used once per requester.
// Latency: a write is visible at the head on the following cycle (no bypass).
// Backpressure: none; the owner's credit counter guarantees it is never written when full.
// Ports: clk, reset (sync active-low), clr (sync clear), wr_en/wr_data, rd_en, rd_data (head), empty.
module fp_alu_scheduler_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rptr[AW-1:0]];
  assign empty   = (wptr == rptr);
endmodule

// fp_alu_scheduler: round-robin two-requester front-end for a fixed-latency FP ALU, steering results to per-requester FIFOs.
// Latency: grant is combinational in the request cycle; the result appears on rspN_* LAT+1 cycles after issue.
// Backpressure: a requester stalls while its credits (in flight + buffered) equal DEPTH; a same-cycle pop frees one.
// Ports: clk, reset (sync active-low), flush; reqN_valid/ready/op/a/b requests; alu_issue/op/a/b to the ALU,
//        alu_res/alu_exc back from it; rspN_valid/ready/data/exc result FIFO heads; busy (work in flight or buffered).
module fp_alu_scheduler #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        alu_issue,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_exc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_exc,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_exc,
  output logic        busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]     req_vld;
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     pop;
  logic [1:0]     rsp_vld;
  logic [1:0]     fifo_empty;
  logic [1:0]     fifo_wr;
  logic [32:0]    head0;
  logic [32:0]    head1;
  logic [CW-1:0]  cnt [2];
  logic           ptr;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;

  assign req_vld = {req1_valid, req0_valid};
  // Outputs are held at zero while reset is low, independent of stored state.
  assign rsp_vld = reset ? ~fifo_empty : 2'b00;
  assign pop     = rsp_vld & {rsp1_ready, rsp0_ready};

  // A pop in the same cycle returns a credit, so a full requester may still be granted.
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_vld[i] && ((cnt[i] < CNT_MAX) || pop[i]) && !flush && reset;
    end
  end

  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign alu_issue  = |grant;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (grant[0]) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (grant[1]) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  // Priority goes to whichever requester lost the last grant.
  always_ff @(posedge clk) begin
    if (!reset || flush)  ptr <= 1'b0;
    else if (grant[0])    ptr <= 1'b1;
    else if (grant[1])    ptr <= 1'b0;
  end

  // Owner tags travel alongside the ALU pipeline; clearing them drops any pre-flush results.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      tag_vld[0] <= alu_issue;
      tag_id[0]  <= grant[1];
    end
  end

  assign fifo_wr = tag_vld[LAT-1] ? (tag_id[LAT-1] ? 2'b10 : 2'b01) : 2'b00;

  // Credits are taken at grant and returned at pop; capture only moves an op from pipe to FIFO.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset || flush)        cnt[i] <= '0;
      else if (grant[i] && !pop[i]) cnt[i] <= cnt[i] + CNT_ONE;
      else if (!grant[i] && pop[i]) cnt[i] <= cnt[i] - CNT_ONE;
    end
  end

  fp_alu_scheduler_fifo #(.W(33), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .wr_en   (fifo_wr[0]),
    .wr_data ({alu_exc, alu_res}),
    .rd_en   (pop[0]),
    .rd_data (head0),
    .empty   (fifo_empty[0])
  );

  fp_alu_scheduler_fifo #(.W(33), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .wr_en   (fifo_wr[1]),
    .wr_data ({alu_exc, alu_res}),
    .rd_en   (pop[1]),
    .rd_data (head1),
    .empty   (fifo_empty[1])
  );

  assign rsp0_valid = rsp_vld[0];
  assign rsp0_data  = rsp_vld[0] ? head0[31:0] : 32'h0;
  assign rsp0_exc   = rsp_vld[0] & head0[32];
  assign rsp1_valid = rsp_vld[1];
  assign rsp1_data  = rsp_vld[1] ? head1[31:0] : 32'h0;
  assign rsp1_exc   = rsp_vld[1] & head1[32];

  assign busy = reset && ((|tag_vld) || (|rsp_vld));
endmodule
